// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the 16x8 FIFO write port between NREQ producers,
// with write-error attribution. Define ARB_BURST_LOCK_EN to hold grants for bursts.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4,
  parameter int STALL_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              fifo_wr_en_o,
  output logic [DW-1:0]     fifo_wdata_o,
  input  logic              fifo_full_i,
  input  logic              fifo_wr_error_i,
  output logic [7:0]        err_cnt_o,
  output logic [2:0]        err_id_o,
  output logic              stall_rel_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
`ifdef ARB_BURST_LOCK_EN
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_MAX - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [2:0]      last_id_q, last_id_d;
  logic            wr_en_q, wr_en_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            stall_rel_q, stall_rel_d;
  logic [7:0]      err_cnt_q;
  logic [2:0]      err_id_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            g_valid, g_last;
  logic [DW-1:0]   g_data;
  logic            accept;
  logic            end_grant;

  // Rotating priority: the search starts just after the previous winner.
  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_idx = IW'((int'(rr_ptr_q) + i) % NREQ);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Signals of the granted requester, selected by the one-hot grant.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        g_valid = req_valid_i[k];
        g_last  = req_last_i[k];
        g_data  = req_data_i[k*DW +: DW];
      end
    end
  end

  assign accept      = (state_q == BURST) && g_valid && !fifo_full_i;
  assign req_ready_o = ((state_q == BURST) && !fifo_full_i) ? grant_q : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    last_id_d   = last_id_q;
    wr_en_d     = accept;
    wdata_d     = wdata_q;
    stall_rel_d = 1'b0;
    end_grant   = 1'b0;

    if (accept) begin
      wdata_d   = g_data;
      last_id_d = 3'(gidx_q);
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          gidx_d   = win_idx;
          rr_ptr_d = win_idx;
          beat_d   = '0;
          stall_d  = '0;
          state_d  = BURST;
        end
      end
      BURST: begin
`ifdef ARB_BURST_LOCK_EN
        if (accept) begin
          beat_d  = beat_q + 1'b1;
          stall_d = '0;
          if (g_last || beat_q == BEAT_LAST) end_grant = 1'b1;
        end else if (!g_valid) begin
          // A full FIFO with valid high is back-pressure, not a stall.
          if (stall_q == STALL_LAST) begin
            stall_rel_d = 1'b1;
            end_grant   = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`else
        if (accept || !g_valid) end_grant = 1'b1;
`endif
        if (end_grant) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef ARB_BURST_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^{g_last, beat_q, stall_q};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      beat_q      <= '0;
      stall_q     <= '0;
      last_id_q   <= '0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
      stall_rel_q <= 1'b0;
      err_cnt_q   <= '0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      last_id_q   <= last_id_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      stall_rel_q <= stall_rel_d;
      // The error refers to the write issued last cycle, still held in last_id.
      if (fifo_wr_error_i) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        err_id_q <= last_id_q;
      end
    end
  end

  assign grant_o      = grant_q;
  assign fifo_wr_en_o = wr_en_q;
  assign fifo_wdata_o = wdata_q;
  assign err_cnt_o    = err_cnt_q;
  assign err_id_o     = err_id_q;
  assign stall_rel_o  = stall_rel_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences and
// a randomized run against a behavioural model (follows ARB_BURST_LOCK_EN).
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int BURST_MAX = 4;
  localparam int STALL_MAX = 8;
`ifdef ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam int BPG = LOCK ? BURST_MAX : 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wdata;
  logic              fifo_full;
  logic              fifo_wr_error;
  logic [7:0]        err_cnt;
  logic [2:0]        err_id;
  logic              stall_rel;

  int total = 0;
  int bad = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX), .STALL_MAX(STALL_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant),
    .fifo_wr_en_o(fifo_wr_en), .fifo_wdata_o(fifo_wdata),
    .fifo_full_i(fifo_full), .fifo_wr_error_i(fifo_wr_error),
    .err_cnt_o(err_cnt), .err_id_o(err_id), .stall_rel_o(stall_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       err;
    logic [3:0] ready;
    logic [3:0] grant;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] err_cnt;
    logic [2:0] err_id;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    fifo_wr_error = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    int idx = 99;
    for (int k = 0; k < 4; k++) if (g[k] && g == (4'b0001 << k)) idx = k;
    return idx;
  endfunction

  task automatic run_table();
    tbl[0]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'd0, 3'd0};
    tbl[1]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h00, 8'd0, 3'd0};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h11, 8'd0, 3'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'd0, 3'd0};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'd1, 3'd1};
    tbl[5]  = '{4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'd1, 3'd1};
    tbl[6]  = '{4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 8'h11, 8'd1, 3'd1};
    tbl[7]  = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'h11, 8'd1, 3'd1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h13, 8'd1, 3'd1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h13, 8'd1, 3'd1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h13, 8'd2, 3'd3};
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].valid;
      req_last = tbl[r].last;
      fifo_full = tbl[r].full;
      fifo_wr_error = tbl[r].err;
      settle();
      check($sformatf("tbl%0d.ready", r), 32'(req_ready), 32'(tbl[r].ready));
      check($sformatf("tbl%0d.grant", r), 32'(grant), 32'(tbl[r].grant));
      check($sformatf("tbl%0d.wr_en", r), 32'(fifo_wr_en), 32'(tbl[r].wr_en));
      check($sformatf("tbl%0d.wdata", r), 32'(fifo_wdata), 32'(tbl[r].wdata));
      check($sformatf("tbl%0d.err_cnt", r), 32'(err_cnt), 32'(tbl[r].err_cnt));
      check($sformatf("tbl%0d.err_id", r), 32'(err_id), 32'(tbl[r].err_id));
      check($sformatf("tbl%0d.stall_rel", r), 32'(stall_rel), 32'd0);
      next_cyc();
    end
    fifo_wr_error = 1'b0;
  endtask

  task automatic run_round_robin();
    int gq[$];
    int wq[$];
    int gaps[$];
    int zr = 0;
    bit seen = 1'b0;
    logic [3:0] prev_g = '0;
    do_reset();
    req_valid = 4'hF;
    req_last = '0;
    req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int c = 0; c < 40; c++) begin
      settle();
      if (fifo_wr_en) wq.push_back(int'(fifo_wdata) - 'h40);
      if (grant != 0 && prev_g == 0) begin
        if (seen) gaps.push_back(zr);
        seen = 1'b1;
        zr = 0;
        gq.push_back(onehot_idx(grant));
      end
      if (grant == 0) zr++;
      prev_g = grant;
      next_cyc();
    end
    check("rr.ngrants", 32'(gq.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) check($sformatf("rr.grant%0d", i), 32'(gq[i]), 32'(i % 4));
    check("rr.nwrites", 32'(wq.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("rr.write%0d", i), 32'(wq[i]), 32'((i / BPG) % 4));
    check("rr.ngaps", 32'(gaps.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("rr.bubble%0d", i), 32'(gaps[i]), 32'd1);
    req_valid = '0;
  endtask

  task automatic run_burst3();
    logic [7:0] beats [3];
    logic [7:0] wd[$];
    int wcyc[$];
    logic [3:0] gr [24];
    int bi = 0;
    int acc3 = -1;
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      req_valid = (bi < 3) ? 4'b0100 : 4'b0000;
      req_last = (bi == 2) ? 4'b0100 : 4'b0000;
      req_data = '0;
      req_data[23:16] = (bi < 3) ? beats[bi] : 8'h00;
      settle();
      gr[c] = grant;
      if (fifo_wr_en) begin
        wd.push_back(fifo_wdata);
        wcyc.push_back(c);
      end
      if (req_valid[2] && req_ready[2]) begin
        if (bi == 2) acc3 = c;
        bi++;
      end
      next_cyc();
    end
    check("burst.nwrites", 32'(wd.size()), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("burst.data%0d", i), 32'(wd[i]), 32'(beats[i]));
    check("burst.gap01", 32'(wcyc[1] - wcyc[0]), LOCK ? 32'd1 : 32'd2);
    check("burst.gap12", 32'(wcyc[2] - wcyc[1]), LOCK ? 32'd1 : 32'd2);
    check("burst.last_seen", 32'(acc3 >= 0), 32'd1);
    if (acc3 >= 0 && acc3 < 23) check("burst.idle_after", 32'(gr[acc3 + 1]), 32'd0);
    check("burst.idle_end", 32'(gr[23]), 32'd0);
    req_valid = '0;
    req_last = '0;
  endtask

  task automatic run_full();
    do_reset();
    req_valid = 4'b0001;
    req_last = '0;
    req_data = 32'h0000_005A;
    settle();
    check("full.idle_grant", 32'(grant), 32'd0);
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      fifo_full = 1'b1;
      settle();
      check($sformatf("full%0d.ready", i), 32'(req_ready), 32'd0);
      check($sformatf("full%0d.grant", i), 32'(grant), 32'b0001);
      check($sformatf("full%0d.wr_en", i), 32'(fifo_wr_en), 32'd0);
      check($sformatf("full%0d.stall_rel", i), 32'(stall_rel), 32'd0);
      next_cyc();
    end
    fifo_full = 1'b0;
    settle();
    check("full.resume_ready", 32'(req_ready), 32'b0001);
    check("full.resume_grant", 32'(grant), 32'b0001);
    next_cyc();
    settle();
    check("full.resume_wr_en", 32'(fifo_wr_en), 32'd1);
    check("full.resume_wdata", 32'(fifo_wdata), 32'h5A);
    req_valid = '0;
  endtask

  task automatic run_stall();
    do_reset();
    req_valid = 4'b0011;
    req_last = '0;
    req_data = 32'h0000_2211;
    settle();
    next_cyc();
    settle();
    check("stall.grant0", 32'(grant), 32'b0001);
    check("stall.ready0", 32'(req_ready), 32'b0001);
    next_cyc();
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'b0010;
      settle();
      check($sformatf("stall%0d.grant", i), 32'(grant),
            LOCK ? 32'b0001 : ((i % 2) ? 32'b0010 : 32'b0000));
      check($sformatf("stall%0d.stall_rel", i), 32'(stall_rel), 32'd0);
      next_cyc();
    end
    settle();
    check("stall.rel_pulse", 32'(stall_rel), 32'(LOCK));
    check("stall.released", 32'(grant), 32'd0);
    next_cyc();
    settle();
    check("stall.rel_gone", 32'(stall_rel), 32'd0);
    check("stall.next_owner", 32'(grant), 32'b0010);
    req_valid = '0;
  endtask

  task automatic run_errors_and_reset();
    do_reset();
    req_valid = 4'b0010;
    req_last = 4'b0010;
    req_data = 32'h0000_3300;
    settle(); next_cyc();
    settle(); next_cyc();
    req_valid = '0;
    req_last = '0;
    settle();
    check("err.write1", 32'(fifo_wr_en), 32'd1);
    next_cyc();
    for (int i = 0; i < 300; i++) begin
      fifo_wr_error = 1'b1;
      settle();
      next_cyc();
    end
    fifo_wr_error = 1'b0;
    settle();
    check("err.sat_cnt", 32'(err_cnt), 32'd255);
    check("err.sat_id", 32'(err_id), 32'd1);
    next_cyc();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    req_data = 32'h0077_0000;
    settle(); next_cyc();
    settle(); next_cyc();
    req_valid = '0;
    req_last = '0;
    settle();
    check("err.write2", 32'(fifo_wr_en), 32'd1);
    check("err.wdata2", 32'(fifo_wdata), 32'h77);
    next_cyc();
    fifo_wr_error = 1'b1;
    settle(); next_cyc();
    fifo_wr_error = 1'b0;
    settle();
    check("err.sat_hold", 32'(err_cnt), 32'd255);
    check("err.sat_id_upd", 32'(err_id), 32'd2);
    next_cyc();
    // Abort a burst with reset while a beat is being accepted.
    req_valid = 4'b0001;
    req_last = '0;
    req_data = 32'h0000_0099;
    settle(); next_cyc();
    settle();
    check("rst.pre_grant", 32'(grant), 32'b0001);
    next_cyc();
    rst = 1'b1;
    settle();
    check("rst.pre_cnt", 32'(err_cnt), 32'd255);
    next_cyc();
    rst = 1'b0;
    req_valid = '0;
    settle();
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst.wdata", 32'(fifo_wdata), 32'd0);
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
    check("rst.err_id", 32'(err_id), 32'd0);
    check("rst.stall_rel", 32'(stall_rel), 32'd0);
  endtask

  // Transaction-level model: an owner (or none), a round-robin pointer and counters.
  task automatic run_random();
    bit         m_busy = 1'b0;
    logic [1:0] m_own = 2'd0;
    logic [1:0] m_rr = 2'd3;
    int         m_beats = 0;
    int         m_stalls = 0;
    logic [2:0] m_last_id = 3'd0;
    logic [2:0] m_err_id = 3'd0;
    logic       m_wr_en = 1'b0;
    logic       m_stall_rel = 1'b0;
    logic [7:0] m_wdata = 8'h00;
    int         m_err_cnt = 0;
    logic [3:0] exp_grant;
    logic [3:0] exp_ready;
    bit         acc;
    bit         found;
    logic [1:0] cand;
    logic [1:0] win;
    int         dens;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dens = (c / 200) % 3;
      for (int k = 0; k < 4; k++) begin
        req_valid[k] = (dens == 0) ? ($urandom_range(0, 3) == 0) :
                       (dens == 1) ? ($urandom_range(0, 4) < 3) : ($urandom_range(0, 9) != 0);
        req_last[k] = ($urandom_range(0, 3) == 0);
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      fifo_wr_error = ($urandom_range(0, 9) == 0);
      req_data = $urandom;
      settle();
      exp_grant = m_busy ? (4'b0001 << m_own) : 4'b0000;
      exp_ready = (m_busy && !fifo_full) ? exp_grant : 4'b0000;
      check($sformatf("rnd%0d.ready", c), 32'(req_ready), 32'(exp_ready));
      check($sformatf("rnd%0d.grant", c), 32'(grant), 32'(exp_grant));
      check($sformatf("rnd%0d.wr_en", c), 32'(fifo_wr_en), 32'(m_wr_en));
      check($sformatf("rnd%0d.wdata", c), 32'(fifo_wdata), 32'(m_wdata));
      check($sformatf("rnd%0d.stall_rel", c), 32'(stall_rel), 32'(m_stall_rel));
      check($sformatf("rnd%0d.err_cnt", c), 32'(err_cnt), 32'(m_err_cnt));
      check($sformatf("rnd%0d.err_id", c), 32'(err_id), 32'(m_err_id));
      acc = m_busy && req_valid[m_own] && !fifo_full;
      if (fifo_wr_error) begin
        if (m_err_cnt < 255) m_err_cnt++;
        m_err_id = m_last_id;
      end
      m_wr_en = acc;
      m_stall_rel = 1'b0;
      if (acc) begin
        m_wdata = req_data[{m_own, 3'b000} +: 8];
        m_last_id = {1'b0, m_own};
      end
      if (!m_busy) begin
        found = 1'b0;
        win = 2'd0;
        for (int i = 1; i <= 4; i++) begin
          cand = m_rr + 2'(i);
          if (!found && req_valid[cand]) begin
            found = 1'b1;
            win = cand;
          end
        end
        if (found) begin
          m_busy = 1'b1;
          m_own = win;
          m_rr = win;
          m_beats = 0;
          m_stalls = 0;
        end
      end else if (LOCK) begin
        if (acc) begin
          m_beats++;
          m_stalls = 0;
          if (req_last[m_own] || m_beats == BURST_MAX) m_busy = 1'b0;
        end else if (!req_valid[m_own]) begin
          if (m_stalls == STALL_MAX - 1) begin
            m_stall_rel = 1'b1;
            m_busy = 1'b0;
          end else begin
            m_stalls++;
          end
        end
      end else if (acc || !req_valid[m_own]) begin
        m_busy = 1'b0;
      end
      next_cyc();
    end
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_wr_error = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    fifo_wr_error = 1'b0;
    run_table();
    run_round_robin();
    run_burst3();
    run_full();
    run_stall();
    run_errors_and_reset();
    run_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
